apb_master_nslv: RTL

APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

---
 rtl/apb_master_nslv_if.sv | 26 ++
 rtl/apb_master_nslv.sv | 108 ++++++++++
 2 files changed

// File: rtl/apb_master_nslv_if.sv
// APB bus between the master bridge and NUM_SLV slaves; psel is one-hot and
// prdata/pready/pslverr carry one slice or bit per slave.
interface apb_master_nslv_if #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NUM_SLV = 4
);
  logic [NUM_SLV-1:0]    psel;
  logic                  penable;
  logic                  pwrite;
  logic [AW-1:0]         paddr;
  logic [DW-1:0]         pwdata;
  logic [NUM_SLV*DW-1:0] prdata;
  logic [NUM_SLV-1:0]    pready;
  logic [NUM_SLV-1:0]    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_nslv.sv
// APB master bridge to NUM_SLV slaves: accept -> SETUP -> ACCESS, done three cycles after accept at best.
// Stalls in ACCESS on pready (bounded by TIMEOUT); requests arriving while busy are dropped, not queued.
module apb_master_nslv #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              transfer,
  input  logic              read_write,
  input  logic [AW-1:0]     apb_write_paddr,
  input  logic [DW-1:0]     apb_write_data,
  input  logic [AW-1:0]     apb_read_paddr,
  output logic [DW-1:0]     apb_read_data_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  apb_master_nslv_if.master apb
);
  localparam int SW = $clog2(NUM_SLV);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state_q, state_d;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [TW-1:0] tcnt_q;
  logic [SW-1:0] sel;
  logic          sel_rdy;
  logic          sel_err;
  logic          tmo;
  logic          complete;
  logic          accept;
  logic [DW-1:0] prdata_arr [NUM_SLV];

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_slice
    assign prdata_arr[i] = apb.prdata[i*DW +: DW];
  end

  // Slave index comes from the top address bits of the latched request.
  assign sel      = addr_q[AW-1 -: SW];
  assign sel_rdy  = apb.pready[sel];
  assign sel_err  = apb.pslverr[sel];
  assign tmo      = !sel_rdy && (tcnt_q == TW'(TIMEOUT - 1));
  assign complete = (state_q == ACCESS) && (sel_rdy || tmo);
  assign accept   = transfer && ((state_q == IDLE) || complete);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (transfer) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (complete) state_d = accept ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    apb.penable = (state_q == ACCESS);
    apb.psel    = '0;
    if (state_q != IDLE) apb.psel[sel] = 1'b1;
    apb.pwrite  = wr_q;
    apb.paddr   = addr_q;
    apb.pwdata  = wdata_q;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_q              <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      tcnt_q            <= '0;
      done              <= 1'b0;
      err               <= 1'b0;
      apb_read_data_out <= '0;
    end else begin
      done <= complete;
      err  <= complete && (sel_err || tmo);
      if (accept) begin
        wr_q    <= !read_write;
        addr_q  <= read_write ? apb_read_paddr : apb_write_paddr;
        wdata_q <= apb_write_data;
      end
      // Counter is zeroed during SETUP so every ACCESS phase starts from 0.
      if (state_q == SETUP) begin
        tcnt_q <= '0;
      end else if ((state_q == ACCESS) && !sel_rdy) begin
        tcnt_q <= tcnt_q + TW'(1);
      end
      if (complete && !wr_q) begin
        apb_read_data_out <= sel_rdy ? prdata_arr[sel] : '0;
      end
    end
  end
endmodule
